// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
// States, instruction classes, opcode/funct values, ALU codes, fault causes.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_FAULT
  } state_t;

  typedef enum logic [2:0] {
    C_R,
    C_IALU,
    C_LW,
    C_SW,
    C_BEQ,
    C_J
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SLL  = 3'b011;
  localparam logic [2:0] ALU_SRL  = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLTU = 3'b111;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

endpackage

// File: rtl/instr_decoder.sv
// Combinational op/funct decode: ALU op, instruction class, extension mode
// and illegal-instruction flag.
module instr_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6
) (
  input  logic [OP_W-1:0]    op_code,
  input  logic [FUNCT_W-1:0] function_code,
  output logic [2:0]         alu_op,
  output iclass_t            iclass,
  output logic               zero_ext,
  output logic               illegal
);

  always_comb begin
    alu_op   = ALU_ADD;
    iclass   = C_R;
    zero_ext = 1'b0;
    illegal  = 1'b0;
    case (op_code)
      OP_W'(OP_RTYPE): begin
        iclass = C_R;
        case (function_code)
          FUNCT_W'(FN_ADD):  alu_op = ALU_ADD;
          FUNCT_W'(FN_SUB):  alu_op = ALU_SUB;
          FUNCT_W'(FN_AND):  alu_op = ALU_AND;
          FUNCT_W'(FN_OR):   alu_op = ALU_OR;
          FUNCT_W'(FN_SLTU): alu_op = ALU_SLTU;
          FUNCT_W'(FN_SLL):  alu_op = ALU_SLL;
          FUNCT_W'(FN_SRL):  alu_op = ALU_SRL;
          default:           illegal = 1'b1;
        endcase
      end
      OP_W'(OP_ADDI): begin
        iclass = C_IALU;
        alu_op = ALU_ADD;
      end
      OP_W'(OP_SLTIU): begin
        iclass = C_IALU;
        alu_op = ALU_SLTU;
      end
      OP_W'(OP_ANDI): begin
        iclass   = C_IALU;
        alu_op   = ALU_AND;
        zero_ext = 1'b1;
      end
      OP_W'(OP_ORI): begin
        iclass   = C_IALU;
        alu_op   = ALU_OR;
        zero_ext = 1'b1;
      end
      OP_W'(OP_LW):  iclass = C_LW;
      OP_W'(OP_SW):  iclass = C_SW;
      OP_W'(OP_BEQ): begin
        iclass = C_BEQ;
        alu_op = ALU_SUB;
      end
      OP_W'(OP_J):   iclass = C_J;
      default:       illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory handshake timeout, illegal-op trap and retired-instruction count.
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int FUNCT_W     = 6,
  parameter int ALU_SEL_W   = 3,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OP_W-1:0]      op_code,
  input  logic [FUNCT_W-1:0]   function_code,
  input  logic                 alu_zero,
  input  logic                 mem_ready,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic                 i_or_d,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [ALU_SEL_W-1:0] select_bits_ALU,
  output logic                 select_zeroOrSign,
  output logic                 select_writeReg,
  output logic                 mem_to_reg,
  output logic                 write_enable,
  output logic                 fault,
  output logic [1:0]           fault_cause,
  output logic [CNT_W-1:0]     instr_count
);

  localparam int WAIT_W =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;

  logic [2:0] alu_op;
  iclass_t    iclass;
  logic       zero_ext;
  logic       illegal;

  instr_decoder #(
    .OP_W    (OP_W),
    .FUNCT_W (FUNCT_W)
  ) u_dec (
    .op_code       (op_code),
    .function_code (function_code),
    .alu_op        (alu_op),
    .iclass        (iclass),
    .zero_ext      (zero_ext),
    .illegal       (illegal)
  );

  logic mem_phase;
  logic timeout_hit;
  logic retire;

  assign mem_phase = (state == S_FETCH) || (state == S_MEM);

  // Ready in the final wait slot wins over the timeout.
  assign timeout_hit = (MEM_TIMEOUT != 0) && mem_phase && !mem_ready &&
    (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    retire = 1'b0;
    case (state)
      S_EXEC:  retire = (iclass == C_BEQ) || (iclass == C_J);
      S_MEM:   retire = (iclass == C_SW) && mem_ready;
      S_WB:    retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_FETCH;
      wait_cnt    <= '0;
      instr_count <= '0;
      fault       <= 1'b0;
      fault_cause <= FAULT_NONE;
    end else begin
      if (retire)
        instr_count <= instr_count + 1'b1;
      if (mem_phase && !mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
      unique case (state)
        S_FETCH: begin
          if (mem_ready) begin
            state <= S_DECODE;
          end else if (timeout_hit) begin
            state       <= S_FAULT;
            fault       <= 1'b1;
            fault_cause <= FAULT_TIMEOUT;
          end
        end
        S_DECODE: begin
          if (illegal) begin
            state       <= S_FAULT;
            fault       <= 1'b1;
            fault_cause <= FAULT_ILLEGAL;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          wait_cnt <= '0;
          case (iclass)
            C_R, C_IALU: state <= S_WB;
            C_LW, C_SW:  state <= S_MEM;
            default:     state <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            state    <= (iclass == C_LW) ? S_WB : S_FETCH;
          end else if (timeout_hit) begin
            state       <= S_FAULT;
            fault       <= 1'b1;
            fault_cause <= FAULT_TIMEOUT;
          end
        end
        S_WB: begin
          wait_cnt <= '0;
          state    <= S_FETCH;
        end
        S_FAULT: state <= S_FAULT;
        default: state <= S_FAULT;
      endcase
    end
  end

  logic [2:0] alu_sel;
  logic [1:0] b_sel;

  assign b_sel = ((iclass == C_R) || (iclass == C_BEQ) ||
                  (iclass == C_J)) ? 2'd0 : 2'd2;

  always_comb begin
    mem_rd            = 1'b0;
    mem_wr            = 1'b0;
    i_or_d            = 1'b0;
    ir_write          = 1'b0;
    pc_write          = 1'b0;
    pc_src            = 2'd0;
    alu_src_a         = 1'b0;
    alu_src_b         = 2'd0;
    alu_sel           = 3'b000;
    select_zeroOrSign = 1'b0;
    select_writeReg   = 1'b0;
    mem_to_reg        = 1'b0;
    write_enable      = 1'b0;
    if (!reset) begin
      unique case (state)
        S_FETCH: begin
          mem_rd    = 1'b1;
          alu_src_b = 2'd1;
          alu_sel   = ALU_ADD;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b         = 2'd3;
          alu_sel           = ALU_ADD;
          select_zeroOrSign = !zero_ext;
        end
        S_EXEC: begin
          alu_src_a         = 1'b1;
          alu_src_b         = b_sel;
          alu_sel           = alu_op;
          select_zeroOrSign = !zero_ext;
          if (iclass == C_BEQ) begin
            pc_src   = 2'd1;
            pc_write = alu_zero;
          end else if (iclass == C_J) begin
            pc_src   = 2'd2;
            pc_write = 1'b1;
          end
        end
        S_MEM: begin
          i_or_d            = 1'b1;
          mem_rd            = (iclass == C_LW);
          mem_wr            = (iclass == C_SW);
          alu_src_a         = 1'b1;
          alu_src_b         = b_sel;
          alu_sel           = alu_op;
          select_zeroOrSign = !zero_ext;
        end
        S_WB: begin
          write_enable      = 1'b1;
          select_writeReg   = (iclass != C_R);
          mem_to_reg        = (iclass == C_LW);
          alu_src_a         = 1'b1;
          alu_src_b         = b_sel;
          alu_sel           = alu_op;
          select_zeroOrSign = !zero_ext;
        end
        default: ;
      endcase
    end
  end

  assign select_bits_ALU = ALU_SEL_W'(alu_sel);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: per-cycle control word
// checked against an instruction-level phase model.
module tb_multicycle_control_unit;

  localparam int TO = 4;

  localparam logic [2:0] K_R   = 3'd0;
  localparam logic [2:0] K_I   = 3'd1;
  localparam logic [2:0] K_LW  = 3'd2;
  localparam logic [2:0] K_SW  = 3'd3;
  localparam logic [2:0] K_BEQ = 3'd4;
  localparam logic [2:0] K_J   = 3'd5;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic [2:0] alu;
    logic [2:0] kind;
    logic       zext;
  } ins_t;

  logic        clk;
  logic        reset;
  logic [5:0]  op_code;
  logic [5:0]  function_code;
  logic        alu_zero;
  logic        mem_ready;
  logic        mem_rd, mem_wr, i_or_d, ir_write, pc_write;
  logic [1:0]  pc_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  select_bits_ALU;
  logic        select_zeroOrSign, select_writeReg;
  logic        mem_to_reg, write_enable, fault;
  logic [1:0]  fault_cause;
  logic [31:0] instr_count;

  multicycle_control_unit #(.MEM_TIMEOUT(TO)) dut (
    .clk               (clk),
    .reset             (reset),
    .op_code           (op_code),
    .function_code     (function_code),
    .alu_zero          (alu_zero),
    .mem_ready         (mem_ready),
    .mem_rd            (mem_rd),
    .mem_wr            (mem_wr),
    .i_or_d            (i_or_d),
    .ir_write          (ir_write),
    .pc_write          (pc_write),
    .pc_src            (pc_src),
    .alu_src_a         (alu_src_a),
    .alu_src_b         (alu_src_b),
    .select_bits_ALU   (select_bits_ALU),
    .select_zeroOrSign (select_zeroOrSign),
    .select_writeReg   (select_writeReg),
    .mem_to_reg        (mem_to_reg),
    .write_enable      (write_enable),
    .fault             (fault),
    .fault_cause       (fault_cause),
    .instr_count       (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp;
  int   n_bad;
  int   exp_cnt;
  ins_t tbl [15];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] cw(
    logic rd, logic wr, logic iod, logic irw, logic pcw, logic [1:0] pcs,
    logic a, logic [1:0] b, logic [2:0] alu, logic zos, logic wreg,
    logic m2r, logic we);
    return {rd, wr, iod, irw, pcw, pcs, a, b, alu, zos, wreg, m2r, we};
  endfunction

  function automatic logic [31:0] obs();
    return 32'({mem_rd, mem_wr, i_or_d, ir_write, pc_write, pc_src,
                alu_src_a, alu_src_b, select_bits_ALU, select_zeroOrSign,
                select_writeReg, mem_to_reg, write_enable});
  endfunction

  function automatic logic [1:0] src_b(ins_t i);
    return (i.kind == K_R || i.kind == K_BEQ || i.kind == K_J) ? 2'd0 : 2'd2;
  endfunction

  function automatic logic [31:0] e_fetch(logic rdy);
    return 32'(cw(1, 0, 0, rdy, rdy, 0, 0, 1, 3'b010, 0, 0, 0, 0));
  endfunction

  function automatic logic [31:0] e_decode(ins_t i);
    return 32'(cw(0, 0, 0, 0, 0, 0, 0, 3, 3'b010, !i.zext, 0, 0, 0));
  endfunction

  function automatic logic [31:0] e_exec(ins_t i, logic z);
    logic [1:0] pcs;
    logic       pcw;
    pcs = (i.kind == K_BEQ) ? 2'd1 : (i.kind == K_J) ? 2'd2 : 2'd0;
    pcw = (i.kind == K_BEQ) ? z : (i.kind == K_J);
    return 32'(cw(0, 0, 0, 0, pcw, pcs, 1, src_b(i), i.alu, !i.zext,
                  0, 0, 0));
  endfunction

  function automatic logic [31:0] e_mem(ins_t i);
    return 32'(cw(i.kind == K_LW, i.kind == K_SW, 1, 0, 0, 0, 1, 2,
                  i.alu, !i.zext, 0, 0, 0));
  endfunction

  function automatic logic [31:0] e_wb(ins_t i);
    return 32'(cw(0, 0, 0, 0, 0, 0, 1, src_b(i), i.alu, !i.zext,
                  i.kind != K_R, i.kind == K_LW, 1));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input int waits);
    for (int c = 0; c <= waits; c++) begin
      mem_ready     = (c == waits);
      op_code       = 6'($urandom);
      function_code = 6'($urandom);
      alu_zero      = 1'($urandom);
      #1 check("fetch", obs(), e_fetch(mem_ready));
      tick();
    end
  endtask

  task automatic run_instr(input ins_t i, input int wf, input int wm,
                           input logic z);
    do_fetch(wf);
    op_code       = i.op;
    function_code = i.fn;
    mem_ready     = 1'($urandom);
    #1 check("decode", obs(), e_decode(i));
    tick();
    alu_zero  = z;
    mem_ready = 1'($urandom);
    #1 check("exec", obs(), e_exec(i, z));
    tick();
    if (i.kind == K_LW || i.kind == K_SW) begin
      for (int c = 0; c <= wm; c++) begin
        mem_ready = (c == wm);
        #1 check("mem", obs(), e_mem(i));
        tick();
      end
    end
    if (i.kind == K_R || i.kind == K_I || i.kind == K_LW) begin
      mem_ready = 1'($urandom);
      #1 check("wb", obs(), e_wb(i));
      tick();
    end
    exp_cnt++;
    check("count", instr_count, 32'(exp_cnt));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1 check("rst_ctrl", obs(), 32'd0);
    check("rst_cnt", instr_count, 32'd0);
    check("rst_fault", {30'd0, fault_cause, fault}, 32'd0);
    tick();
    check("rst_hold", obs(), 32'd0);
    reset   = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic expect_fault(input logic [1:0] cause, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      mem_ready = 1'($urandom);
      alu_zero  = 1'($urandom);
      #1 check("flt_ctrl", obs(), 32'd0);
      check("flt_flag", {30'd0, fault_cause, fault}, {29'd0, cause, 1'b1});
      check("flt_cnt", instr_count, 32'(exp_cnt));
      tick();
    end
  endtask

  function automatic bit legal_op(logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h0B, 6'h0C, 6'h0D,
                      6'h23, 6'h2B};
  endfunction

  function automatic bit legal_fn(logic [5:0] fn);
    return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2B, 6'h00, 6'h02};
  endfunction

  task automatic run_illegal(input logic [5:0] op, input logic [5:0] fn);
    ins_t bad;
    bad = '{op: op, fn: fn, alu: 3'b010, kind: K_R, zext: 1'b0};
    do_fetch(0);
    op_code       = op;
    function_code = fn;
    #1 check("ill_dec", obs(), e_decode(bad));
    check("ill_nofault", {31'd0, fault}, 32'd0);
    tick();
    expect_fault(2'b01, 10);
    do_reset();
  endtask

  initial begin
    ins_t       i;
    logic [5:0] r;
    n_cmp   = 0;
    n_bad   = 0;
    exp_cnt = 0;
    tbl[0]  = '{6'h00, 6'h20, 3'b010, K_R, 1'b0};
    tbl[1]  = '{6'h00, 6'h22, 3'b110, K_R, 1'b0};
    tbl[2]  = '{6'h00, 6'h24, 3'b000, K_R, 1'b0};
    tbl[3]  = '{6'h00, 6'h25, 3'b001, K_R, 1'b0};
    tbl[4]  = '{6'h00, 6'h2B, 3'b111, K_R, 1'b0};
    tbl[5]  = '{6'h00, 6'h00, 3'b011, K_R, 1'b0};
    tbl[6]  = '{6'h00, 6'h02, 3'b100, K_R, 1'b0};
    tbl[7]  = '{6'h08, 6'h15, 3'b010, K_I, 1'b0};
    tbl[8]  = '{6'h0B, 6'h3A, 3'b111, K_I, 1'b0};
    tbl[9]  = '{6'h0C, 6'h07, 3'b000, K_I, 1'b1};
    tbl[10] = '{6'h0D, 6'h11, 3'b001, K_I, 1'b1};
    tbl[11] = '{6'h23, 6'h09, 3'b010, K_LW, 1'b0};
    tbl[12] = '{6'h2B, 6'h30, 3'b010, K_SW, 1'b0};
    tbl[13] = '{6'h04, 6'h01, 3'b110, K_BEQ, 1'b0};
    tbl[14] = '{6'h02, 6'h3F, 3'b010, K_J, 1'b0};

    reset         = 1'b1;
    mem_ready     = 1'b0;
    alu_zero      = 1'b0;
    op_code       = '0;
    function_code = '0;
    #2 check("rst_ctrl0", obs(), 32'd0);
    check("rst_cnt0", instr_count, 32'd0);
    check("rst_flt0", {30'd0, fault_cause, fault}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_instr(tbl[0], 0, 0, 1'b0);
    run_instr(tbl[11], 0, 3, 1'b0);
    run_instr(tbl[13], 0, 0, 1'b1);
    run_instr(tbl[13], 0, 0, 1'b0);
    run_instr(tbl[14], 0, 0, 1'b0);
    run_instr(tbl[12], 3, 0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      i = tbl[$urandom_range(0, 14)];
      run_instr(i, ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO - 1) : 0,
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO - 1) : 0,
                1'($urandom));
    end

    // Reset mid-wait in the MEM phase of an lw.
    do_fetch(0);
    op_code       = tbl[11].op;
    function_code = tbl[11].fn;
    tick();
    tick();
    for (int c = 0; c < 2; c++) begin
      mem_ready = 1'b0;
      #1 check("lw_mem_wait", obs(), e_mem(tbl[11]));
      tick();
    end
    do_reset();
    mem_ready = 1'b0;
    #1 check("post_rst_fetch", obs(), e_fetch(1'b0));
    check("post_rst_cnt", instr_count, 32'd0);
    tick();
    run_instr(tbl[7], 0, 0, 1'b0);

    run_illegal(6'h3F, 6'h20);
    for (int n = 0; n < 4; n++) begin
      do r = 6'($urandom); while (legal_op(r));
      run_illegal(r, 6'($urandom));
      do r = 6'($urandom); while (legal_fn(r));
      run_illegal(6'h00, r);
    end

    // Instruction fetch never answered.
    run_instr(tbl[9], 0, 0, 1'b0);
    for (int c = 0; c < TO; c++) begin
      mem_ready = 1'b0;
      #1 check("to_fetch", obs(), e_fetch(1'b0));
      check("to_nofault", {31'd0, fault}, 32'd0);
      tick();
    end
    expect_fault(2'b10, 3);
    do_reset();

    // Ready on the last allowed wait cycle wins.
    run_instr(tbl[3], TO - 1, 0, 1'b0);
    run_instr(tbl[11], TO - 1, TO - 1, 1'b0);

    // Data access never answered.
    do_fetch(0);
    op_code       = tbl[12].op;
    function_code = tbl[12].fn;
    tick();
    tick();
    for (int c = 0; c < TO; c++) begin
      mem_ready = 1'b0;
      #1 check("to_mem", obs(), e_mem(tbl[12]));
      tick();
    end
    expect_fault(2'b10, 3);
    do_reset();
    run_instr(tbl[14], 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
